cbfp_denorm: RTL and testbench

// Receive end of the CBFP chain: undoes per-lane block-floating-point normalisation at the FFT output.
// - Stage-1 CBFP shift indices arrive early (idx_valid) and queue in an internal FIFO.
// - The matching 16-lane data beat arrives later with its own stage-2 indices.
// - Per lane: indices are summed, the 12-bit sample is rescaled and saturated, then emitted with frame markers.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/idx_fifo.sv | 69 ++++++
 rtl/cbfp_denorm.sv | 120 ++++++++++++
 tb/tb_cbfp_denorm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT back-end types and constants for the CBFP receive path.
package fft_pkg;

   localparam int LANES       = 16;
   localparam int IN_WIDTH    = 12;
   localparam int OUT_WIDTH   = 13;
   localparam int IDX_WIDTH   = 5;
   localparam int NORM_BIAS   = 9;
   localparam int FRAME_BEATS = 32;

   // Summed stage-1 + stage-2 index needs one extra bit.
   localparam int TOT_WIDTH   = IDX_WIDTH + 1;
   // Sample after the fixed left pre-shift.
   localparam int WIDE_WIDTH  = IN_WIDTH + NORM_BIAS;

   typedef logic [IDX_WIDTH-1:0]        shift_idx_t;
   typedef shift_idx_t [LANES-1:0]      idx_beat_t;
   typedef logic signed [OUT_WIDTH-1:0] out_t;

   // Clamp a pre-shifted value into the signed OUT_WIDTH range.
   function automatic out_t sat_s(input logic signed [WIDE_WIDTH-1:0] x);
      logic signed [WIDE_WIDTH-1:0] hi;
      logic signed [WIDE_WIDTH-1:0] lo;
      hi = {{(WIDE_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      lo = {{(WIDE_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
      if (x > hi)      return hi[OUT_WIDTH-1:0];
      else if (x < lo) return lo[OUT_WIDTH-1:0];
      else             return x[OUT_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/idx_fifo.sv
// Stage-1 index FIFO: one idx_beat_t per entry, with empty-bypass and
// error pulses for drop-on-full and read-while-empty.
module idx_fifo
   import fft_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        push_i,
   input  idx_beat_t   wdata_i,
   input  logic        pop_i,
   output idx_beat_t   rdata_o,
   output logic [AW:0] level_o,
   output logic        ovf_o,
   output logic        unf_o
);

   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   idx_beat_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          full, empty, do_wr, do_rd;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);

   // A push into an empty FIFO that is popped in the same cycle bypasses storage.
   assign do_wr = push_i & (~full | pop_i) & ~(empty & pop_i);
   assign do_rd = pop_i & ~empty;

   assign rdata_o = empty ? (push_i ? wdata_i : '0) : mem_q[rd_ptr_q];
   assign ovf_o   = push_i & full & ~pop_i;
   assign unf_o   = pop_i & empty & ~push_i;
   assign level_o = level_q;

   // Pointer/level next state; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_wr && !do_rd) level_d = level_q + 1'b1;
      if (do_rd && !do_wr) level_d = level_q - 1'b1;
   end

   // Pointer/level registers; reset discards anything queued.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cbfp_denorm.sv
// CBFP denormaliser: pairs queued stage-1 indices with incoming data beats,
// rescales each lane by the summed index, saturates, and tags frame edges.
module cbfp_denorm
   import fft_pkg::*;
#(
   parameter int FIFO_DEPTH = 64
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                idx_valid,
   input  idx_beat_t                           shift_idx1,
   input  logic                                din_valid,
   input  logic [LANES-1:0][IN_WIDTH-1:0]      din_i,
   input  logic [LANES-1:0][IN_WIDTH-1:0]      din_q,
   input  idx_beat_t                           shift_idx2,
   input  logic                                err_clr,
   output logic                                valid_out,
   output logic [LANES-1:0][OUT_WIDTH-1:0]     dout_i,
   output logic [LANES-1:0][OUT_WIDTH-1:0]     dout_q,
   output logic                                frame_start,
   output logic                                frame_end,
   output logic                                err_overflow,
   output logic                                err_underflow,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

   localparam int              FB_W      = $clog2(FRAME_BEATS);
   localparam logic [FB_W-1:0] LAST_BEAT = FB_W'(FRAME_BEATS - 1);

   idx_beat_t       idx1;
   logic            fifo_ovf, fifo_unf;
   logic [1:0]      vld_q;
   logic [FB_W-1:0] cnt_q, cnt_d;
   logic            ovf_q, unf_q;

   idx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (idx_valid),
      .wdata_i (shift_idx1),
      .pop_i   (din_valid),
      .rdata_o (idx1),
      .level_o (fifo_level),
      .ovf_o   (fifo_ovf),
      .unf_o   (fifo_unf)
   );

   // Valid travels alongside the two datapath stages.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) vld_q <= '0;
      else       vld_q <= {vld_q[0], din_valid};
   end

   // Sticky errors: a new error wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q & ~err_clr) | fifo_ovf;
         unf_q <= (unf_q & ~err_clr) | fifo_unf;
      end
   end

   // Output beat position within the frame; idle gaps hold the count.
   always_comb begin
      cnt_d = cnt_q;
      if (vld_q[1]) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
   end

   // Frame beat counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign valid_out     = vld_q[1];
   assign frame_start   = vld_q[1] & (cnt_q == '0);
   assign frame_end     = vld_q[1] & (cnt_q == LAST_BEAT);
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [IN_WIDTH-1:0]          di_q, dq_q;
      logic [TOT_WIDTH-1:0]         tot_q;
      logic signed [WIDE_WIDTH-1:0] wi, wq, si, sq;
      logic [OUT_WIDTH-1:0]         oi_q, oq_q;

      // Pre-shift left by NORM_BIAS, then arithmetic right shift (floors).
      assign wi = {di_q, {NORM_BIAS{1'b0}}};
      assign wq = {dq_q, {NORM_BIAS{1'b0}}};
      assign si = wi >>> tot_q;
      assign sq = wq >>> tot_q;

      // Stage 1 captures the sample and summed index; stage 2 the saturated result.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            di_q  <= '0;
            dq_q  <= '0;
            tot_q <= '0;
            oi_q  <= '0;
            oq_q  <= '0;
         end else begin
            if (din_valid) begin
               di_q  <= din_i[l];
               dq_q  <= din_q[l];
               tot_q <= {1'b0, idx1[l]} + {1'b0, shift_idx2[l]};
            end
            if (vld_q[0]) begin
               oi_q <= sat_s(si);
               oq_q <= sat_s(sq);
            end
         end
      end

      assign dout_i[l] = oi_q;
      assign dout_q[l] = oq_q;
   end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Randomised + directed bench for cbfp_denorm against a queue-based reference model.
module tb_cbfp_denorm;
   import fft_pkg::*;

   localparam int DEPTH = 64;
   typedef logic [LANES-1:0][IN_WIDTH-1:0] dbeat_t;

   typedef struct {
      int due;
      int oi[LANES];
      int oq[LANES];
      bit fs;
      bit fe;
   } exp_t;

   logic      clk = 1'b0;
   logic      rstn = 1'b0;
   logic      idx_valid = 1'b0, din_valid = 1'b0, err_clr = 1'b0;
   idx_beat_t shift_idx1 = '0, shift_idx2 = '0;
   dbeat_t    din_i = '0, din_q = '0;
   logic      valid_out, frame_start, frame_end, err_overflow, err_underflow;
   logic [LANES-1:0][OUT_WIDTH-1:0] dout_i, dout_q;
   logic [6:0] fifo_level;

   cbfp_denorm #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .idx_valid(idx_valid), .shift_idx1(shift_idx1),
      .din_valid(din_valid), .din_i(din_i), .din_q(din_q), .shift_idx2(shift_idx2),
      .err_clr(err_clr), .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q),
      .frame_start(frame_start), .frame_end(frame_end), .err_overflow(err_overflow),
      .err_underflow(err_underflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0, n_err = 0;

   // Reference state
   idx_beat_t mq[$];
   exp_t      eq[$];
   bit        m_ovf = 0, m_unf = 0;
   int        m_cnt = 0;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // floor(d * 2^NORM_BIAS / 2^t) clamped to the 13-bit signed range
   function automatic int ref_denorm(input int d, input int t);
      real div, v;
      div = 1.0;
      for (int k = 0; k < t; k++) div = div * 2.0;
      v = $floor(real'(d) * 512.0 / div);
      if (v > 4095.0)       return 4095;
      else if (v < -4096.0) return -4096;
      else                  return int'(v);
   endfunction

   function automatic idx_beat_t rnd_idx();
      idx_beat_t r;
      for (int l = 0; l < LANES; l++) r[l] = 5'($urandom_range(0, 31));
      return r;
   endfunction

   function automatic dbeat_t rnd_dat();
      dbeat_t r;
      for (int l = 0; l < LANES; l++) r[l] = 12'($urandom_range(0, 4095));
      return r;
   endfunction

   task automatic check_outputs();
      exp_t e;
      if (eq.size() > 0 && eq[0].due < cyc) begin
         chk("beat_lost", 0, 1);
         void'(eq.pop_front());
      end
      if (eq.size() > 0 && eq[0].due == cyc) begin
         e = eq.pop_front();
         chk("valid_out", valid_out, 1);
         for (int l = 0; l < LANES; l++) begin
            chk($sformatf("dout_i[%0d]", l), $signed(dout_i[l]), e.oi[l]);
            chk($sformatf("dout_q[%0d]", l), $signed(dout_q[l]), e.oq[l]);
         end
         chk("frame_start", frame_start, e.fs);
         chk("frame_end", frame_end, e.fe);
      end else begin
         chk("valid_idle", valid_out, 0);
         chk("fs_idle", frame_start, 0);
      end
      chk("fifo_level", fifo_level, mq.size());
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_underflow", err_underflow, m_unf);
   endtask

   // One clock: check at negedge, drive, advance the model, wait for posedge.
   task automatic step(input bit push, input idx_beat_t i1, input bit dv,
                       input dbeat_t di, input dbeat_t dq, input idx_beat_t i2, input bit clr);
      exp_t      e;
      idx_beat_t p;
      int        sz, t;
      bit        no, nu;
      @(negedge clk);
      check_outputs();
      idx_valid = push; shift_idx1 = i1; din_valid = dv;
      din_i = di; din_q = dq; shift_idx2 = i2; err_clr = clr;
      sz = mq.size(); no = 0; nu = 0; p = '0;
      if (dv) begin
         if (sz > 0)    p = mq.pop_front();
         else if (push) p = i1;
         else           nu = 1;
      end
      if (push && !(dv && sz == 0)) begin
         if (sz < DEPTH || dv) mq.push_back(i1);
         else                  no = 1;
      end
      m_ovf = (m_ovf && !clr) || no;
      m_unf = (m_unf && !clr) || nu;
      if (dv) begin
         e.due = cyc + 2;
         for (int l = 0; l < LANES; l++) begin
            t = int'(p[l]) + int'(i2[l]);
            e.oi[l] = ref_denorm(int'($signed(di[l])), t);
            e.oq[l] = ref_denorm(int'($signed(dq[l])), t);
         end
         e.fs = (m_cnt % FRAME_BEATS) == 0;
         e.fe = (m_cnt % FRAME_BEATS) == FRAME_BEATS - 1;
         m_cnt++;
         eq.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, '0, 0, '0, '0, '0, 0);
   endtask

   task automatic chk_reset_zero(input string tag);
      chk({tag, "_valid"}, valid_out, 0);
      chk({tag, "_dout_i"}, |dout_i, 0);
      chk({tag, "_dout_q"}, |dout_q, 0);
      chk({tag, "_fs"}, frame_start, 0);
      chk({tag, "_fe"}, frame_end, 0);
      chk({tag, "_ovf"}, err_overflow, 0);
      chk({tag, "_unf"}, err_underflow, 0);
      chk({tag, "_level"}, fifo_level, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rstn = 1'b0;
      idx_valid = 0; din_valid = 0; err_clr = 0;
      #1 chk_reset_zero(tag);
      mq.delete(); eq.delete();
      m_ovf = 0; m_unf = 0; m_cnt = 0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      idx_beat_t i1, i2;
      dbeat_t    di, dq;
      bit        pu, dv, cl;

      // Power-on reset
      #12 chk_reset_zero("rst0");
      @(negedge clk);
      rstn = 1'b1;

      // Arithmetic: lane0 I 100 >> (3+4) path, lane1 Q -100 with total 12
      i1 = '0; i1[0] = 5'd3; i1[1] = 5'd6;
      step(1, i1, 0, '0, '0, '0, 0);
      di = '0; di[0] = 12'd100;
      dq = '0; dq[1] = 12'hF9C;
      i2 = '0; i2[0] = 5'd4; i2[1] = 5'd6;
      step(0, '0, 1, di, dq, i2, 0);
      idle(1);
      #1 chk("arith_i", $signed(dout_i[0]), 400);
      chk("arith_q_floor", $signed(dout_q[1]), -13);

      // Saturation, delivered through the empty-FIFO bypass
      i1 = '0; i1[2] = 5'd31;
      di = '0; di[0] = 12'h7FF; di[1] = 12'h800; di[2] = 12'h001;
      i2 = '0; i2[2] = 5'd31;
      step(1, i1, 1, di, '0, i2, 0);
      idle(1);
      #1 chk("sat_hi", $signed(dout_i[0]), 4095);
      chk("sat_lo", $signed(dout_i[1]), -4096);
      chk("shift_62", $signed(dout_i[2]), 0);
      chk("bypass_level", fifo_level, 0);
      chk("bypass_unf", err_underflow, 0);

      // Reset with indices queued and beats in flight
      step(1, rnd_idx(), 0, '0, '0, '0, 0);
      step(1, rnd_idx(), 1, rnd_dat(), rnd_dat(), rnd_idx(), 0);
      step(1, rnd_idx(), 1, rnd_dat(), rnd_dat(), rnd_idx(), 0);
      do_reset("rst_mid");

      // Skew: 40 index beats ahead of 40 data beats
      for (int k = 0; k < 40; k++) step(1, rnd_idx(), 0, '0, '0, '0, 0);
      #1 chk("skew_peak", fifo_level, 40);
      for (int k = 0; k < 40; k++) step(0, '0, 1, rnd_dat(), rnd_dat(), rnd_idx(), 0);
      idle(3);

      // Overflow: 65 pushes into an empty FIFO
      for (int k = 0; k < 65; k++) step(1, rnd_idx(), 0, '0, '0, '0, 0);
      #1 chk("ovf_set", err_overflow, 1);
      chk("ovf_level", fifo_level, 64);
      step(0, '0, 0, '0, '0, '0, 1);
      #1 chk("ovf_clr", err_overflow, 0);
      step(1, rnd_idx(), 1, rnd_dat(), rnd_dat(), rnd_idx(), 0);
      #1 chk("full_pushpop_level", fifo_level, 64);
      chk("full_pushpop_ovf", err_overflow, 0);
      for (int k = 0; k < 64; k++) step(0, '0, 1, rnd_dat(), rnd_dat(), rnd_idx(), 0);

      // Underflow: idx1 treated as 0, so 1 << 9 >> 2 = 128
      di = '0; di[0] = 12'd1;
      i2 = '0; i2[0] = 5'd2;
      step(0, '0, 1, di, '0, i2, 0);
      idle(1);
      #1 chk("unf_set", err_underflow, 1);
      chk("unf_idx0", $signed(dout_i[0]), 128);
      step(0, '0, 1, rnd_dat(), rnd_dat(), rnd_idx(), 1);
      #1 chk("unf_clr_collide", err_underflow, 1);
      step(0, '0, 0, '0, '0, '0, 1);
      #1 chk("unf_clr", err_underflow, 0);
      chk("ovf_clr2", err_overflow, 0);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         pu = $urandom_range(0, 99) < 55;
         dv = $urandom_range(0, 99) < 50;
         cl = $urandom_range(0, 99) < 3;
         step(pu, rnd_idx(), dv, rnd_dat(), rnd_dat(), rnd_idx(), cl);
      end
      idle(4);
      chk("eq_drained", eq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
